// File: rtl/float32_vec_feeder.sv
// Buffers a float32 vector from a valid/ready stream, then clears the downstream
// accumulator for one cycle and replays the vector one word per cycle.
module float32_vec_feeder #(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] len,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        acc_rst,
  output logic [15:0] acc_len,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StClear, StStream} state_e;

  state_e      state_q, state_d;
  logic [15:0] wr_q, wr_d;
  logic [15:0] rd_q, rd_d;
  logic [15:0] acc_len_q, acc_len_d;
  logic        done_d, err_d, wr_en;
  logic        out_valid_d, out_last_d;
  logic [31:0] out_data_d;
  logic        len_ok;

  logic [31:0] mem_q [DEPTH];

  assign len_ok  = (len != 16'd0) && ({1'b0, len} <= 17'(DEPTH));
  assign acc_len = acc_len_q;

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    acc_len_d = acc_len_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (len_ok) begin
            acc_len_d = len;
            wr_d      = 16'd0;
            rd_d      = 16'd0;
            state_d   = StLoad;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (in_valid) begin
          wr_en = 1'b1;
          wr_d  = wr_q + 16'd1;
          if (wr_d == acc_len_q) state_d = StClear;
        end
      end
      StClear: begin
        rd_d    = 16'd0;
        state_d = StStream;
      end
      StStream: begin
        if (rd_q == acc_len_q - 16'd1) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          rd_d = rd_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Output registers are loaded from next-state so every output is a flop.
    out_valid_d = (state_d == StStream);
    out_data_d  = out_valid_d ? mem_q[rd_d[AW-1:0]] : 32'd0;
    out_last_d  = out_valid_d && (rd_d == acc_len_q - 16'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      wr_q      <= 16'd0;
      rd_q      <= 16'd0;
      acc_len_q <= 16'd0;
      in_ready  <= 1'b0;
      acc_rst   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      acc_len_q <= acc_len_d;
      in_ready  <= (state_d == StLoad);
      acc_rst   <= (state_d == StClear);
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_last  <= out_last_d;
      busy      <= (state_d != StIdle);
      done      <= done_d;
      err       <= err_d;
    end
  end

  // Buffer has no reset; contents are only read after being rewritten.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_float32_vec_feeder.sv
// Directed bench for float32_vec_feeder: framing, gaps, bad lengths, full depth,
// ignored start, mid-operation reset and back-to-back vectors.
module tb_float32_vec_feeder;

  localparam int unsigned DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        acc_rst;
  logic [15:0] acc_len;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_w [32];

  float32_vec_feeder #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .acc_rst  (acc_rst),
    .acc_len  (acc_len),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_vec(input int l);
    start = 1'b1;
    len   = 16'(l);
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_after_start", in_ready, 1);
    chk("acc_len_latched", acc_len, 32'(l));
  endtask

  // Feeds exp_w[0..n-1] with `gap` idle cycles between words.
  task automatic load_vec(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          tick();
          chk("in_ready_gap", in_ready, 1);
          chk("acc_rst_gap", acc_rst, 0);
        end
      end
      in_valid = 1'b1;
      in_data  = exp_w[i];
      tick();
      if (i < n - 1) chk("in_ready_load", in_ready, 1);
    end
    in_valid = 1'b0;
    in_data  = 32'd0;
    chk("acc_rst_pulse", acc_rst, 1);
    chk("in_ready_clear", in_ready, 0);
    chk("out_valid_clear", out_valid, 0);
  endtask

  // Checks STREAM cycles and stops in the done cycle.
  task automatic stream_vec(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, exp_w[k]);
      chk("out_last", out_last, 32'(k == n - 1));
      chk("acc_rst_stream", acc_rst, 0);
      chk("acc_len_stream", acc_len, 32'(n));
    end
    tick();
    chk("done", done, 1);
    chk("busy_done", busy, 0);
    chk("out_valid_idle", out_valid, 0);
    chk("out_data_idle", out_data, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 16'd0; in_valid = 1'b0; in_data = 32'd0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_acc_rst", acc_rst, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_acc_len", acc_len, 0);
    rst = 1'b0;
    tick();

    // Basic vector
    exp_w[0] = 32'h3F800000; exp_w[1] = 32'h40000000;
    exp_w[2] = 32'h40400000; exp_w[3] = 32'h40800000;
    begin_vec(4);
    load_vec(4, 0);
    stream_vec(4);
    tick();
    chk("done_one_cycle", done, 0);

    // Gapped input
    exp_w[0] = 32'hC0A00000; exp_w[1] = 32'h3F000000; exp_w[2] = 32'h7F7FFFFF;
    begin_vec(3);
    load_vec(3, 2);
    stream_vec(3);
    tick();

    // Bad lengths
    start = 1'b1; len = 16'd0;
    tick();
    start = 1'b0;
    chk("err_len0", err, 1);
    chk("busy_len0", busy, 0);
    chk("in_ready_len0", in_ready, 0);
    tick();
    chk("err_len0_clear", err, 0);
    start = 1'b1; len = 16'(DEPTH + 1);
    tick();
    start = 1'b0;
    chk("err_len_big", err, 1);
    chk("busy_len_big", busy, 0);
    chk("in_ready_len_big", in_ready, 0);
    tick();
    chk("err_len_big_clear", err, 0);
    chk("acc_len_unchanged", acc_len, 3);

    // Full depth
    for (int k = 0; k < int'(DEPTH); k++) exp_w[k] = 32'(k);
    begin_vec(DEPTH);
    load_vec(DEPTH, 0);
    stream_vec(DEPTH);
    tick();

    // Ignored start in LOAD, then reset mid-operation
    begin_vec(5);
    in_valid = 1'b1; in_data = 32'h11111111;
    start = 1'b1; len = 16'd9;
    tick();
    start = 1'b0;
    chk("acc_len_ignored_start", acc_len, 5);
    chk("err_ignored_start", err, 0);
    chk("busy_ignored_start", busy, 1);
    in_data = 32'h22222222;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("busy_after_rst", busy, 0);
    chk("acc_len_after_rst", acc_len, 0);
    chk("in_ready_after_rst", in_ready, 0);
    chk("done_after_rst", done, 0);
    tick();
    chk("done_after_rst2", done, 0);
    chk("err_after_rst2", err, 0);
    exp_w[0] = 32'hDEADBEEF; exp_w[1] = 32'h00000001;
    begin_vec(2);
    load_vec(2, 1);
    stream_vec(2);

    // Back-to-back: start issued in the done cycle
    exp_w[0] = 32'hBF800000;
    begin_vec(1);
    load_vec(1, 0);
    stream_vec(1);
    tick();
    chk("final_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/float32_vec_feeder.md
# float32_vec_feeder

Upstream stage for the float32 N-element accumulator. Collects a vector of `len` IEEE-754 single-precision words from a valid/ready input stream into an internal buffer, then resets the accumulator for one cycle and replays the vector back-to-back, one word per cycle, with a stable element count alongside. Words are not interpreted arithmetically; the block only buffers, sequences and frames them.

## Interface
- `DEPTH`, default 64: buffer capacity in words; maximum accepted `len`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a vector; honoured only in IDLE.
- `len`  in  16  vector length, sampled when `start` is honoured.
- `in_valid`  in  1  input word present.
- `in_data`  in  32  input float32 word.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `acc_rst`  out  1  one-cycle clear pulse for the downstream accumulator.
- `acc_len`  out  16  latched `len`, stable from the cycle after `start` until return to IDLE.
- `out_valid`  out  1  `out_data` carries a vector element this cycle.
- `out_data`  out  32  vector element, in arrival order.
- `out_last`  out  1  marks the final element.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the final element.
- `err`  out  1  one-cycle pulse on a rejected `start`.

## Operation
- States: IDLE, LOAD, CLEAR, STREAM.
- IDLE:
  - `start`=1 with 1 ≤ `len` ≤ DEPTH: latch `len` into `acc_len`, zero write/read counters, go to LOAD.
  - `start`=1 with `len`=0 or `len`>DEPTH: pulse `err` next cycle and stay in IDLE.
  - `in_valid` is ignored because `in_ready`=0.
- LOAD:
  - `in_ready`=1.
  - Each edge with `in_valid`&`in_ready` writes `in_data` to buffer[wr_cnt] and increments wr_cnt.
  - On the accept that makes wr_cnt == `acc_len`, go to CLEAR.
- CLEAR:
  - One cycle.
  - `acc_rst`=1 and `in_ready`=0.
  - Go to STREAM.
- STREAM:
  - `acc_len` cycles, with `out_valid`=1 in every one.
  - In STREAM cycle k (0-based), `out_data` = buffer[k].
  - `out_last`=1 only in cycle k = `acc_len`-1.
  - There is no backpressure; downstream consumes one word per cycle.
  - After the last element, go to IDLE.
  - `done`=1 in the first IDLE cycle.
- `start` outside IDLE is ignored: no `err`, and `len` is not re-sampled.
- Counters are 16 bits; wr_cnt and rd_cnt never exceed DEPTH, so no wrap-around is possible.
- Buffer contents are not cleared by reset. They are don't-care until rewritten.
- Reset mid-operation, in any state:
  - Next cycle: IDLE.
  - Partial vector discarded.
  - No `done` or `err` is emitted.
  - `acc_len` is cleared to 0.

## Timing
- Reset values:
  - `in_ready`, `acc_rst`, `out_valid`, `out_last`, `busy`, `done` and `err` are 0.
  - `out_data` and `acc_len` are 0.
  - State is IDLE.
- All outputs are registered; none is combinationally dependent on inputs.
- `start` at edge T: `busy`=1 and `in_ready`=1 from cycle T+1.
- L-th accept at edge E: `in_ready`=0 and `acc_rst`=1 in cycle E+1.
- STREAM cycles are E+2 … E+L+1.
- `done`=1 in cycle E+L+2; `busy`=0 from E+L+2.
- `out_data` is 0 whenever `out_valid`=0.
- Minimum turnaround: a new `start` in the `done` cycle is honoured.
- Input gaps (`in_valid`=0) in LOAD only stretch LOAD; the output timing relative to the L-th accept is unchanged.

## Test plan
- **Basic vector:** reset; `start` with `len`=4; feed 0x3F800000, 0x40000000, 0x40400000, 0x40800000 on consecutive cycles.
  - `acc_rst` pulses once.
  - The next 4 cycles carry the words in order, with `out_last` on 0x40800000.
  - `done` follows; `acc_len`=4 throughout.
- **Gapped input:** `len`=3, with `in_valid` low for 2 cycles between each word.
  - STREAM output is identical to a gapless run.
  - `acc_rst` is exactly 1 cycle after the 3rd accept.
- **Bad length:** `start` with `len`=0, then `len`=DEPTH+1.
  - `err` pulses once per request.
  - `busy` stays 0 and `in_ready` stays 0.
- **Full depth:** `len`=DEPTH with words 0..DEPTH-1 (as raw data).
  - DEPTH consecutive `out_valid` cycles with `out_data`=k.
  - `out_last` only on k=DEPTH-1.
- **Ignored start and reset mid-operation:**
  - `len`=5; pulse `start` with `len`=9 during LOAD. `acc_len` stays 5.
  - Then assert `rst` after 2 accepts: next cycle `busy`=0, `acc_len`=0, and no `done`.
  - A new `len`=2 vector then completes normally.
- **Back-to-back:** `start` `len`=1 in the `done` cycle of the previous vector.
  - Accepted; `busy`=1 next cycle.
  - A single STREAM cycle has both `out_valid` and `out_last` set.
